iter_multiplier: RTL and testbench

ITER_MULTIPLIER -- requirements
Module: iter_multiplier

---
 rtl/iter_multiplier_if.sv | 30 +++
 rtl/iter_multiplier.sv | 111 +++++++++++
 tb/tb_iter_multiplier.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/iter_multiplier_if.sv
// Operand/result bundle between the control unit and the iterative multiplier.
// Signed exists only when ITER_MUL_SIGNED_EN is defined.
interface iter_multiplier_if;
  logic        Start;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic        High;
`ifdef ITER_MUL_SIGNED_EN
  logic        Signed;
`endif
  logic        Busy;
  logic        Done;
  logic [63:0] Result;

  modport master (
`ifdef ITER_MUL_SIGNED_EN
    output Signed,
`endif
    output Start, BusA, BusB, High,
    input  Busy, Done, Result
  );

  modport slave (
`ifdef ITER_MUL_SIGNED_EN
    input  Signed,
`endif
    input  Start, BusA, BusB, High,
    output Busy, Done, Result
  );
endinterface

// File: rtl/iter_multiplier.sv
// 64x64 shift-add multiplier, one bit per cycle, 65-cycle latency.
// ITER_MUL_SIGNED_EN adds signed operands via magnitude + sign fix-up.
module iter_multiplier (
  input logic              Clk,
  input logic              Reset,
  iter_multiplier_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [63:0]    a_q, a_d;
  logic           hsel_q, hsel_d;
  logic [127:0]   prod_q, prod_d;
  logic [63:0]    result_q, result_d;
  logic [63:0]    mag_a, mag_b;
  logic [64:0]    sum;
  logic [127:0]   fin;
  logic [63:0]    sel;

`ifdef ITER_MUL_SIGNED_EN
  logic neg_q, neg_d;
  logic neg_in;

  // -2^63 negates to itself, which read unsigned is its magnitude
  always_comb begin
    mag_a  = (bus.Signed && bus.BusA[63]) ? -bus.BusA : bus.BusA;
    mag_b  = (bus.Signed && bus.BusB[63]) ? -bus.BusB : bus.BusB;
    neg_in = bus.Signed & (bus.BusA[63] ^ bus.BusB[63]);
    fin    = neg_q ? -prod_q : prod_q;
  end
`else
  always_comb begin
    mag_a = bus.BusA;
    mag_b = bus.BusB;
    fin   = prod_q;
  end
`endif

  assign sel = hsel_q ? fin[127:64] : fin[63:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    hsel_d   = hsel_q;
    prod_d   = prod_q;
    result_d = result_q;
    sum      = {1'b0, prod_q[127:64]}
             + (prod_q[0] ? {1'b0, a_q} : 65'd0);
`ifdef ITER_MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d     = mag_a;
          prod_d  = {64'd0, mag_b};
          hsel_d  = bus.High;
          cnt_d   = 7'd0;
`ifdef ITER_MUL_SIGNED_EN
          neg_d   = neg_in;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = {sum, prod_q[63:1]};
        cnt_d  = cnt_q + 7'd1;
        if (cnt_q == 7'd63) state_d = DONE;
      end
      DONE: begin
        result_d = sel;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 7'd0;
      a_q      <= 64'd0;
      hsel_q   <= 1'b0;
      prod_q   <= 128'd0;
      result_q <= 64'd0;
`ifdef ITER_MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      hsel_q   <= hsel_d;
      prod_q   <= prod_d;
      result_q <= result_d;
`ifdef ITER_MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.Busy   = (state_q != IDLE);
  assign bus.Done   = (state_q == DONE);
  assign bus.Result = (state_q == DONE) ? sel : result_q;
endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench for iter_multiplier: random and directed operands
// against a plain-arithmetic product model; checks value and latency.
module tb_iter_multiplier;
  logic Clk;
  logic Reset;
  iter_multiplier_if bus ();

  iter_multiplier dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] exp;
    int          issue;
    string       name;
  } sb_t;

  sb_t         sb[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  logic [63:0] last_exp = 64'd0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic hi, input logic sg);
    logic [127:0] p;
    if (sg)
      p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    else
      p = {64'd0, a} * {64'd0, b};
    return hi ? p[127:64] : p[63:0];
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input string name, input logic [63:0] a,
                       input logic [63:0] b, input logic hi,
                       input logic sg);
    int w;
    sb_t e;
    w = 0;
    while (bus.Busy && w < 300) begin
      step();
      w++;
    end
    if (bus.Busy) begin
      total++;
      $display("FAIL %s: busy timeout got 1 expected 0", name);
    end
    bus.Start = 1'b1;
    bus.BusA  = a;
    bus.BusB  = b;
    bus.High  = hi;
`ifdef ITER_MUL_SIGNED_EN
    bus.Signed = sg;
`endif
    e.exp   = model(a, b, hi, sg);
    e.issue = cyc + 1;
    e.name  = name;
    sb.push_back(e);
    step();
    bus.Start = 1'b0;
    bus.BusA  = {$urandom, $urandom};
    bus.BusB  = {$urandom, $urandom};
    bus.High  = ~hi;
`ifdef ITER_MUL_SIGNED_EN
    bus.Signed = ~sg;
`endif
  endtask

  // monitor: pops on every Done pulse; checks hold value while idle
  initial begin
    sb_t e;
    forever begin
      @(negedge Clk);
      if (!Reset && bus.Done) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got %h expected none",
                   bus.Result);
        end else begin
          e = sb.pop_front();
          chk(e.name, bus.Result, e.exp);
          chk({e.name, "_lat"}, 64'(cyc - e.issue), 64'd64);
          last_exp = e.exp;
        end
      end else if (!Reset && !bus.Busy) begin
        chk("hold", bus.Result, last_exp);
      end
    end
  end

  initial begin
    logic [63:0] a, b;
    logic        hi, sg;
    int          w;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.BusA  = 64'd0;
    bus.BusB  = 64'd0;
    bus.High  = 1'b0;
`ifdef ITER_MUL_SIGNED_EN
    bus.Signed = 1'b0;
`endif
    repeat (3) step();
    bus.Start = 1'b1;
    bus.BusA  = 64'd9;
    bus.BusB  = 64'd9;
    step();
    Reset     = 1'b0;
    bus.Start = 1'b0;
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_result", bus.Result, 64'd0);
    step();
    chk("rst_start_dropped", 64'(bus.Busy), 64'd0);

    issue("mul_3x5", 64'd3, 64'd5, 1'b0, 1'b0);
    step();
    chk("busy_run", 64'(bus.Busy), 64'd1);
    issue("ones_hi", '1, '1, 1'b1, 1'b0);
    issue("ones_lo", '1, '1, 1'b0, 1'b0);

    issue("restart_7x9", 64'd7, 64'd9, 1'b0, 1'b0);
    repeat (9) step();
    bus.Start = 1'b1;
    bus.BusA  = 64'd2;
    bus.BusB  = 64'd2;
    step();
    bus.Start = 1'b0;
    chk("restart_busy", 64'(bus.Busy), 64'd1);

    issue("abort", 64'd123, 64'd456, 1'b0, 1'b0);
    repeat (29) step();
    Reset = 1'b1;
    last_exp = 64'd0;
    void'(sb.pop_back());
    step();
    Reset = 1'b0;
    chk("abort_busy", 64'(bus.Busy), 64'd0);
    chk("abort_done", 64'(bus.Done), 64'd0);
    chk("abort_result", bus.Result, 64'd0);
    repeat (80) step();
    issue("mul_4x4", 64'd4, 64'd4, 1'b0, 1'b0);

    issue("min_hi", 64'h8000000000000000, 64'd2, 1'b1, 1'b0);
    issue("min_lo", 64'h8000000000000000, 64'd2, 1'b0, 1'b0);
    issue("zero_a", 64'd0, '1, 1'b0, 1'b0);
    issue("zero_b", '1, 64'd0, 1'b1, 1'b0);
`ifdef ITER_MUL_SIGNED_EN
    issue("s_m2x3_lo", -64'sd2, 64'd3, 1'b0, 1'b1);
    issue("s_m2x3_hi", -64'sd2, 64'd3, 1'b1, 1'b1);
    issue("s_min_hi", 64'h8000000000000000, -64'sd1, 1'b1, 1'b1);
    issue("s_min_lo", 64'h8000000000000000, 64'd3, 1'b0, 1'b1);
    issue("s_minsq_hi", 64'h8000000000000000,
          64'h8000000000000000, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) a = 64'd0;
      if ($urandom_range(0, 9) == 0) b = 64'h8000000000000000;
      hi = 1'($urandom_range(0, 1));
      sg = 1'b0;
`ifdef ITER_MUL_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`endif
      issue("rand", a, b, hi, sg);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) step();
    end

    w = 0;
    while (sb.size() != 0 && w < 300) begin
      step();
      w++;
    end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
